btn_control_unit: RTL and testbench
===================================

// Module: btn_control_unit
// PURPOSE
//   Upstream control stage for counter_10000. Converts three raw push-buttons into the
//   counter's run_stop / clear / mode controls: 2-flop synchronise, debounce, rising-edge
//   detect, then a STOP/RUN/CLEAR FSM plus a mode toggle flop. Outputs drive counter_10000
//   inputs of the same name directly, replacing the slide switches.
// PARAMETERS
//   DEBOUNCE_CYCLES  100_000  consecutive clk cycles a synced input must differ from its
//                             debounced state before that state flips (1 ms @ 100 MHz); >=2
// PORTS
//   clk           input   1  system clock, all state on posedge clk
//   reset         input   1  asynchronous, active-high reset
//   btn_run_stop  input   1  raw run/stop button, active-high, asynchronous to clk
//   btn_clear     input   1  raw clear button, active-high, asynchronous to clk
//   btn_mode      input   1  raw mode button, active-high, asynchronous to clk
//   run_stop      output  1  1 = counter runs; registered
//   clear         output  1  1-cycle clear pulse to counter; registered
//   mode          output  1  0 = up count, 1 = down count; registered
// BEHAVIOUR
//   Reset: sync flops, debounced states, edge flops, debounce counters = 0; FSM = STOP;
//     run_stop = 0, clear = 0, mode = 0. No output glitches on reset release.
//   Per button (3 identical channels):
//   - sync: 2 flops; synced value = second flop.
//   - debounce: counter width $clog2(DEBOUNCE_CYCLES+1). If synced == debounced state,
//     counter <= 0. Otherwise counter increments; on the cycle it equals
//     DEBOUNCE_CYCLES-1 and synced still differs, state <= synced and counter <= 0.
//     Bounces shorter than DEBOUNCE_CYCLES cycles are fully rejected.
//   - edge: press = debounced & ~debounced_d (1 cycle wide, combinational from flops).
//     Releases produce no event.
//   - Latency: a clean raw edge arriving before clk edge 0 changes the affected output
//     at clk edge DEBOUNCE_CYCLES+3, exactly.
//   - A button held through reset release counts as one press after debounce.
//   FSM (registered outputs, Moore):
//   - STOP : run_stop=0, clear=0. clear press -> CLEAR; else run_stop press -> RUN.
//   - RUN  : run_stop=1, clear=0. run_stop press -> STOP; clear press ignored.
//   - CLEAR: run_stop=0, clear=1. Unconditionally -> STOP next cycle. Presses arriving
//            during CLEAR are dropped.
//   - Simultaneous run_stop and clear presses in STOP: clear wins.
//   - Unreachable encodings -> STOP.
//   Mode: any mode press toggles mode in any FSM state, independent of and concurrent
//     with FSM transitions. Mode is not affected by clear.
//   A button held indefinitely generates exactly one press. A second press requires a
//     debounced release followed by a debounced press.
//   Reset asserted mid-debounce or mid-CLEAR aborts immediately to reset values.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1 reset, all buttons 0 for 20 cycles -> run_stop=0, clear=0, mode=0 throughout.
//   2 btn_run_stop 0->1 held -> run_stop=1 exactly 7 edges later.
//     Release, then press again -> run_stop=0.
//   3 btn_run_stop pulses of 3 cycles, repeated with 1-cycle gaps -> no output change,
//     no press.
//   4 In STOP, press btn_clear -> clear=1 for exactly one cycle, then STOP.
//     In RUN, press btn_clear -> run_stop stays 1, clear stays 0.
//   5 In STOP, press btn_clear and btn_run_stop together -> single clear pulse,
//     end in STOP with run_stop=0.
//   6 Press btn_mode in RUN -> mode=1, run_stop stays 1. Press again -> mode=0.
//     Assert reset mid-debounce -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/btn_control_unit.sv
// Button front end for counter_10000: sync, debounce, edge detect, and run/stop/clear FSM.
// Ports: clk, reset (async, active-high); raw buttons btn_run_stop/btn_clear/btn_mode;
// registered outputs run_stop (1=run), clear (1-cycle pulse), mode (0=up, 1=down).
module btn_control_unit #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run_stop,
  input  logic btn_clear,
  input  logic btn_mode,
  output logic run_stop,
  output logic clear,
  output logic mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = run_stop, 1 = clear, 2 = mode
  localparam int RS = 0;
  localparam int CL = 1;
  localparam int MD = 2;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  logic [2:0]    w_btn;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [2:0]    w_press;
  logic [2:0]    r_press;
  logic [CW-1:0] r_cnt [3];
  state_t        r_state;

  assign w_btn = {btn_mode, btn_clear, btn_run_stop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // State flips only after the synced level has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CMAX) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_d;

  // Presses are registered once more so the FSM sees a clean flop input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_d  <= '0;
      r_press <= '0;
    end else begin
      r_db_d  <= r_db;
      r_press <= w_press;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_STOP;
      run_stop <= 1'b0;
      clear    <= 1'b0;
      mode     <= 1'b0;
    end else begin
      mode <= mode ^ r_press[MD];
      case (r_state)
        ST_STOP: begin
          if (r_press[CL]) begin
            r_state  <= ST_CLEAR;
            run_stop <= 1'b0;
            clear    <= 1'b1;
          end else if (r_press[RS]) begin
            r_state  <= ST_RUN;
            run_stop <= 1'b1;
            clear    <= 1'b0;
          end else begin
            r_state  <= ST_STOP;
            run_stop <= 1'b0;
            clear    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_press[RS]) begin
            r_state  <= ST_STOP;
            run_stop <= 1'b0;
          end else begin
            r_state  <= ST_RUN;
            run_stop <= 1'b1;
          end
          clear <= 1'b0;
        end
        ST_CLEAR: begin
          r_state  <= ST_STOP;
          run_stop <= 1'b0;
          clear    <= 1'b0;
        end
        default: begin
          r_state  <= ST_STOP;
          run_stop <= 1'b0;
          clear    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_control_unit.sv
// Directed bench for btn_control_unit with DEBOUNCE_CYCLES = 4.
// Output latency from a raw edge is 7 posedges; all checks at negedge.
module tb_btn_control_unit;

  logic clk = 1'b0;
  logic reset;
  logic b_rs;
  logic b_cl;
  logic b_md;
  logic run_stop;
  logic clear;
  logic mode;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int c0;

  btn_control_unit #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (b_rs),
    .btn_clear    (b_cl),
    .btn_mode     (b_md),
    .run_stop     (run_stop),
    .clear        (clear),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clear === 1'b1) clr_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    {b_md, b_cl, b_rs} = m;
    cyc(hold);
    {b_md, b_cl, b_rs} = 3'b000;
    cyc(12);
  endtask

  initial begin
    reset = 1'b1;
    {b_md, b_cl, b_rs} = 3'b000;
    cyc(3);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle", {run_stop, clear, mode}, 0);
    end

    b_rs = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rs_latency", run_stop, (i >= 7) ? 1 : 0);
    end
    cyc(10);
    check("rs_held", run_stop, 1);
    b_rs = 1'b0;
    cyc(12);
    check("rs_release", run_stop, 1);
    press(3'b001, 10);
    check("rs_second", run_stop, 0);

    c0 = clr_cnt;
    repeat (6) begin
      b_rs = 1'b1;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        check("bounce_hi", run_stop, 0);
      end
      b_rs = 1'b0;
      cyc(1);
      check("bounce_lo", run_stop, 0);
    end
    cyc(12);
    check("bounce_end", {run_stop, clear, mode}, 0);
    check("bounce_noclr", clr_cnt - c0, 0);

    c0 = clr_cnt;
    b_cl = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("clr_pulse", clear, (i == 7) ? 1 : 0);
      check("clr_stop", run_stop, 0);
    end
    b_cl = 1'b0;
    cyc(12);
    check("clr_count", clr_cnt - c0, 1);

    press(3'b001, 10);
    check("to_run", run_stop, 1);
    c0 = clr_cnt;
    press(3'b010, 10);
    check("run_clr_rs", run_stop, 1);
    check("run_clr_cnt", clr_cnt - c0, 0);

    press(3'b001, 10);
    check("to_stop", run_stop, 0);
    c0 = clr_cnt;
    press(3'b011, 10);
    check("both_cnt", clr_cnt - c0, 1);
    check("both_rs", run_stop, 0);

    press(3'b001, 10);
    check("run_again", run_stop, 1);
    press(3'b100, 10);
    check("mode_1", mode, 1);
    check("mode_1_rs", run_stop, 1);
    press(3'b100, 10);
    check("mode_0", mode, 0);
    check("mode_0_rs", run_stop, 1);
    press(3'b100, 10);
    check("mode_1b", mode, 1);

    b_rs = 1'b1;
    cyc(3);
    reset = 1'b1;
    #1;
    check("rst_rs", run_stop, 0);
    check("rst_clr", clear, 0);
    check("rst_mode", mode, 0);
    cyc(3);
    reset = 1'b0;
    cyc(12);
    check("held_rst_rs", run_stop, 1);
    check("held_rst_md", mode, 0);
    b_rs = 1'b0;
    cyc(12);
    check("held_rst_rel", run_stop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
